// File: rtl/hyperbus_tf_splitter.sv
// hyperbus_tf_splitter
// Splits one HyperBus transfer into chunks. A chunk never exceeds the configured
// maximum burst, never crosses a 2^BoundaryLog2-byte row boundary, and is routed
// to the chip selected by the address bits just above cfg_addr_mask_msb_i.
// Each chunk carries its chip select, chip-local address and the 48-bit CA word.
//
// Handshakes: both interfaces use valid/ready. A beat transfers on the rising
// clock edge where valid and ready are both high. Once valid is asserted, the
// producer holds valid and all payload signals stable until that edge.
// tf_ready_o is high only in IDLE. chunk_valid_o is high only in EMIT.
// busy_o exposes the FSM state (low = IDLE, high = EMIT).
module hyperbus_tf_splitter #(
  parameter int AddrWidth    = 32,
  parameter int BurstWidth   = 15,
  parameter int NumChips     = 2,
  parameter int BoundaryLog2 = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [15:0]           cfg_max_words_i,
  input  logic [4:0]            cfg_addr_mask_msb_i,
  input  logic                  tf_valid_i,
  output logic                  tf_ready_o,
  input  logic                  tf_write_i,
  input  logic [BurstWidth-1:0] tf_burst_i,
  input  logic                  tf_burst_type_i,
  input  logic                  tf_addr_space_i,
  input  logic [AddrWidth-1:0]  tf_addr_i,
  output logic                  chunk_valid_o,
  input  logic                  chunk_ready_i,
  output logic                  chunk_write_o,
  output logic                  chunk_burst_type_o,
  output logic                  chunk_addr_space_o,
  output logic [BurstWidth-1:0] chunk_burst_o,
  output logic [AddrWidth-1:0]  chunk_addr_o,
  output logic [NumChips-1:0]   chunk_cs_o,
  output logic                  chunk_last_o,
  output logic [47:0]           chunk_ca_o,
  output logic                  busy_o
);

  localparam int CsWidth = (NumChips > 1) ? $clog2(NumChips) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  state_e state_q, state_d;

  // Latched transfer and configuration (cfg is frozen for the whole transfer)
  logic                  write_q;
  logic                  burst_type_q;
  logic                  addr_space_q;
  logic [AddrWidth-1:0]  addr_q;
  logic [BurstWidth-1:0] rem_q;
  logic [15:0]           max_q;
  logic [4:0]            mask_msb_q;

  // Derived per-chunk values
  logic                  emit;
  logic                  accept;
  logic                  chunk_fire;
  logic [16:0]           btb_words;
  logic [BurstWidth-1:0] len;
  logic                  last_int;
  logic [5:0]            shamt;
  logic [AddrWidth-1:0]  addr_mask;
  logic [AddrWidth-1:0]  local_addr;
  logic [CsWidth-1:0]    cs_idx;
  logic [NumChips-1:0]   cs_dec;
  logic [31:0]           wa;
  logic [47:0]           ca;

  assign emit       = (state_q == EMIT);
  assign tf_ready_o = (state_q == IDLE);
  assign accept     = tf_valid_i & tf_ready_o;
  assign chunk_fire = emit & chunk_ready_i;
  assign busy_o     = emit;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: IDLE accepts one transfer, EMIT walks its chunks until the last one is taken
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (chunk_ready_i && last_int) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Transfer latch on accept; advance address and remaining count after each non-final chunk
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      write_q      <= 1'b0;
      burst_type_q <= 1'b0;
      addr_space_q <= 1'b0;
      addr_q       <= '0;
      rem_q        <= '0;
      max_q        <= '0;
      mask_msb_q   <= '0;
    end else if (accept) begin
      write_q      <= tf_write_i;
      burst_type_q <= tf_burst_type_i;
      addr_space_q <= tf_addr_space_i;
      // Bursts are word-aligned, so the byte-select bit is dropped.
      addr_q       <= tf_addr_i & ~AddrWidth'(1);
      rem_q        <= (tf_burst_i == '0) ? BurstWidth'(1) : tf_burst_i;
      max_q        <= cfg_max_words_i;
      mask_msb_q   <= cfg_addr_mask_msb_i;
    end else if (chunk_fire && !last_int) begin
      addr_q <= addr_q + (AddrWidth'(len) << 1);
      rem_q  <= rem_q - len;
    end
  end

  // Chunk length: the smallest of remaining words, max words and words to the row boundary.
  // Compared at 17 bits so the 16-bit max and the boundary distance never overflow.
  always_comb begin
    btb_words = ((17'd1 << BoundaryLog2) - 17'(addr_q[BoundaryLog2-1:0])) >> 1;
    len       = rem_q;
    // Wrapped bursts and register accesses go out whole.
    if (burst_type_q && !addr_space_q) begin
      if ((max_q != 16'd0) && (17'(max_q) < 17'(len))) begin
        len = BurstWidth'(max_q);
      end
      if (btb_words < 17'(len)) begin
        len = BurstWidth'(btb_words);
      end
    end
    last_int = (len == rem_q);
  end

  // Chip-select decode, chip-local address and CA word for the current chunk
  always_comb begin
    shamt      = {1'b0, mask_msb_q} + 6'd1;
    addr_mask  = ~({AddrWidth{1'b1}} << shamt);
    local_addr = addr_q & addr_mask;
    cs_idx     = CsWidth'(addr_q >> shamt);
    if (NumChips == 1) begin
      cs_dec = '1;
    end else begin
      cs_dec = NumChips'(1) << cs_idx;
    end
    wa = 32'(local_addr >> 1);
    ca = {~write_q, addr_space_q, burst_type_q, wa[31:3], 13'd0, wa[2:0]};
  end

  // Chunk outputs are held at zero outside EMIT
  always_comb begin
    chunk_valid_o      = emit;
    chunk_write_o      = emit & write_q;
    chunk_burst_type_o = emit & burst_type_q;
    chunk_addr_space_o = emit & addr_space_q;
    chunk_burst_o      = emit ? len : '0;
    chunk_addr_o       = emit ? local_addr : '0;
    chunk_cs_o         = emit ? cs_dec : '0;
    chunk_last_o       = emit & last_int;
    chunk_ca_o         = emit ? ca : '0;
  end

endmodule

// File: tb/tb_hyperbus_tf_splitter.sv
// Directed bench for hyperbus_tf_splitter (default parameters).
module tb_hyperbus_tf_splitter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] cfg_max_words_i;
  logic [4:0]  cfg_addr_mask_msb_i;
  logic        tf_valid_i;
  logic        tf_ready_o;
  logic        tf_write_i;
  logic [14:0] tf_burst_i;
  logic        tf_burst_type_i;
  logic        tf_addr_space_i;
  logic [31:0] tf_addr_i;
  logic        chunk_valid_o;
  logic        chunk_ready_i;
  logic        chunk_write_o;
  logic        chunk_burst_type_o;
  logic        chunk_addr_space_o;
  logic [14:0] chunk_burst_o;
  logic [31:0] chunk_addr_o;
  logic [1:0]  chunk_cs_o;
  logic        chunk_last_o;
  logic [47:0] chunk_ca_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  // Attributes of the transfer currently in flight, used to build expected CA words
  logic cur_w, cur_bt, cur_sp;

  hyperbus_tf_splitter dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .cfg_max_words_i     (cfg_max_words_i),
    .cfg_addr_mask_msb_i (cfg_addr_mask_msb_i),
    .tf_valid_i          (tf_valid_i),
    .tf_ready_o          (tf_ready_o),
    .tf_write_i          (tf_write_i),
    .tf_burst_i          (tf_burst_i),
    .tf_burst_type_i     (tf_burst_type_i),
    .tf_addr_space_i     (tf_addr_space_i),
    .tf_addr_i           (tf_addr_i),
    .chunk_valid_o       (chunk_valid_o),
    .chunk_ready_i       (chunk_ready_i),
    .chunk_write_o       (chunk_write_o),
    .chunk_burst_type_o  (chunk_burst_type_o),
    .chunk_addr_space_o  (chunk_addr_space_o),
    .chunk_burst_o       (chunk_burst_o),
    .chunk_addr_o        (chunk_addr_o),
    .chunk_cs_o          (chunk_cs_o),
    .chunk_last_o        (chunk_last_o),
    .chunk_ca_o          (chunk_ca_o),
    .busy_o              (busy_o)
  );

  // Clock
  always #5 clk_i = ~clk_i;

  // Time limit
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "time limit reached");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] model_ca(input logic [31:0] a, input logic w,
                                           input logic sp, input logic bt);
    logic [31:0] wa;
    wa = a >> 1;
    return {~w, sp, bt, wa[31:3], 13'd0, wa[2:0]};
  endfunction

  // Present one transfer at a negedge; returns at the negedge after acceptance
  task automatic send_tf(input string tag, input logic w, input logic [14:0] burst,
                         input logic bt, input logic sp, input logic [31:0] addr);
    chk($sformatf("%s.tf_ready", tag), 64'(tf_ready_o), 64'd1);
    tf_valid_i      = 1'b1;
    tf_write_i      = w;
    tf_burst_i      = burst;
    tf_burst_type_i = bt;
    tf_addr_space_i = sp;
    tf_addr_i       = addr;
    cur_w = w; cur_bt = bt; cur_sp = sp;
    @(posedge clk_i);
    @(negedge clk_i);
    tf_valid_i = 1'b0;
  endtask

  // Chunk must be on the outputs now; optionally stall, then consume it
  task automatic expect_chunk(input string tag, input logic [31:0] e_addr,
                              input logic [14:0] e_burst, input logic e_last,
                              input logic [1:0] e_cs, input int stall, input logic hold);
    logic [47:0] e_ca;
    e_ca = model_ca(e_addr, cur_w, cur_sp, cur_bt);
    chk($sformatf("%s.valid", tag), 64'(chunk_valid_o), 64'd1);
    chk($sformatf("%s.addr", tag),  64'(chunk_addr_o),  64'(e_addr));
    chk($sformatf("%s.burst", tag), 64'(chunk_burst_o), 64'(e_burst));
    chk($sformatf("%s.last", tag),  64'(chunk_last_o),  64'(e_last));
    chk($sformatf("%s.cs", tag),    64'(chunk_cs_o),    64'(e_cs));
    chk($sformatf("%s.ca", tag),    64'(chunk_ca_o),    64'(e_ca));
    chk($sformatf("%s.attr", tag),
        64'({chunk_write_o, chunk_burst_type_o, chunk_addr_space_o}),
        64'({cur_w, cur_bt, cur_sp}));
    chk($sformatf("%s.busy", tag),  64'({busy_o, tf_ready_o}), 64'b10);
    for (int i = 0; i < stall; i++) begin
      chunk_ready_i = 1'b0;
      @(posedge clk_i);
      @(negedge clk_i);
      chk($sformatf("%s.hold_valid", tag), 64'(chunk_valid_o), 64'd1);
      chk($sformatf("%s.hold_addr", tag),  64'(chunk_addr_o),  64'(e_addr));
      chk($sformatf("%s.hold_burst", tag), 64'(chunk_burst_o), 64'(e_burst));
      chk($sformatf("%s.hold_last", tag),  64'(chunk_last_o),  64'(e_last));
    end
    chunk_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    if (!hold) chunk_ready_i = 1'b0;
  endtask

  // Idle after the last chunk: no chunk, ready for a new transfer
  task automatic expect_idle(input string tag);
    chk($sformatf("%s.idle_valid", tag), 64'(chunk_valid_o), 64'd0);
    chk($sformatf("%s.idle_ready", tag), 64'({tf_ready_o, busy_o}), 64'b10);
  endtask

  initial begin
    // Reset
    rst_i               = 1'b1;
    cfg_max_words_i     = 16'd0;
    cfg_addr_mask_msb_i = 5'd25;
    tf_valid_i          = 1'b0;
    tf_write_i          = 1'b0;
    tf_burst_i          = '0;
    tf_burst_type_i     = 1'b0;
    tf_addr_space_i     = 1'b0;
    tf_addr_i           = '0;
    chunk_ready_i       = 1'b0;
    cur_w = 1'b0; cur_bt = 1'b0; cur_sp = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst.tf_ready", 64'(tf_ready_o), 64'd1);
    chk("rst.valid",    64'(chunk_valid_o), 64'd0);
    chk("rst.busy",     64'(busy_o), 64'd0);
    chk("rst.payload",  64'({chunk_burst_o, chunk_addr_o, chunk_cs_o, chunk_last_o}), 64'd0);
    chk("rst.ca",       64'(chunk_ca_o), 64'd0);
    chk("rst.attr",     64'({chunk_write_o, chunk_burst_type_o, chunk_addr_space_o}), 64'd0);

    // 1: boundary split at 0x400
    send_tf("t1", 1'b1, 15'd20, 1'b1, 1'b0, 32'h0000_03F0);
    expect_chunk("t1.c0", 32'h3F0, 15'd8,  1'b0, 2'b01, 0, 1'b0);
    expect_chunk("t1.c1", 32'h400, 15'd12, 1'b1, 2'b01, 0, 1'b0);
    expect_idle("t1");

    // 2: max-words split, back-to-back; cfg change after accept is ignored
    cfg_max_words_i = 16'd4;
    chunk_ready_i   = 1'b1;
    send_tf("t2", 1'b0, 15'd10, 1'b1, 1'b0, 32'h0000_0000);
    cfg_max_words_i = 16'd0;
    expect_chunk("t2.c0", 32'h00, 15'd4, 1'b0, 2'b01, 0, 1'b1);
    expect_chunk("t2.c1", 32'h08, 15'd4, 1'b0, 2'b01, 0, 1'b1);
    expect_chunk("t2.c2", 32'h10, 15'd2, 1'b1, 2'b01, 0, 1'b0);
    expect_idle("t2");

    // 3: read CA word, wrapped burst unsplit, register space unsplit
    send_tf("t3a", 1'b0, 15'd20, 1'b1, 1'b0, 32'h0000_03F0);
    chk("t3a.ca_const", 64'(chunk_ca_o), 64'h0000_A000_003F_0000);
    expect_chunk("t3a.c0", 32'h3F0, 15'd8,  1'b0, 2'b01, 0, 1'b0);
    expect_chunk("t3a.c1", 32'h400, 15'd12, 1'b1, 2'b01, 0, 1'b0);
    send_tf("t3b", 1'b1, 15'd16, 1'b0, 1'b0, 32'h0000_03F8);
    expect_chunk("t3b.c0", 32'h3F8, 15'd16, 1'b1, 2'b01, 0, 1'b0);
    cfg_max_words_i = 16'd4;
    send_tf("t3c", 1'b0, 15'd20, 1'b1, 1'b1, 32'h0000_03F0);
    expect_chunk("t3c.c0", 32'h3F0, 15'd20, 1'b1, 2'b01, 0, 1'b0);
    cfg_max_words_i = 16'd0;
    // burst 0 counts as one word; odd address drops bit 0
    send_tf("t3d", 1'b1, 15'd0, 1'b1, 1'b0, 32'h0000_0123);
    expect_chunk("t3d.c0", 32'h122, 15'd1, 1'b1, 2'b01, 0, 1'b0);

    // 4: second chip select, chip-local address
    send_tf("t4", 1'b1, 15'd4, 1'b1, 1'b0, 32'h0400_0010);
    expect_chunk("t4.c0", 32'h10, 15'd4, 1'b1, 2'b10, 0, 1'b0);
    expect_idle("t4");

    // 5: test-1 stimulus with 5 stall cycles per chunk
    send_tf("t5", 1'b1, 15'd20, 1'b1, 1'b0, 32'h0000_03F0);
    expect_chunk("t5.c0", 32'h3F0, 15'd8,  1'b0, 2'b01, 5, 1'b0);
    expect_chunk("t5.c1", 32'h400, 15'd12, 1'b1, 2'b01, 5, 1'b0);
    expect_idle("t5");

    // 6: reset while the second chunk of test 2 is presented
    cfg_max_words_i = 16'd4;
    send_tf("t6", 1'b0, 15'd10, 1'b1, 1'b0, 32'h0000_0000);
    expect_chunk("t6.c0", 32'h00, 15'd4, 1'b0, 2'b01, 0, 1'b0);
    chk("t6.c1_addr", 64'(chunk_addr_o), 64'h8);
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("t6.rst_valid", 64'(chunk_valid_o), 64'd0);
    chk("t6.rst_ready", 64'(tf_ready_o), 64'd1);
    chk("t6.rst_busy",  64'(busy_o), 64'd0);
    cfg_max_words_i = 16'd0;
    send_tf("t6n", 1'b1, 15'd20, 1'b1, 1'b0, 32'h0000_03F0);
    expect_chunk("t6n.c0", 32'h3F0, 15'd8,  1'b0, 2'b01, 0, 1'b0);
    expect_chunk("t6n.c1", 32'h400, 15'd12, 1'b1, 2'b01, 0, 1'b0);
    expect_idle("t6n");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
